// File: rtl/pll_mdrp_pkg.sv
// Shared constants and types for the PLL dynamic reconfiguration port initiator.
// Opcode encodings, FSM state encoding and the default register address width.
package pll_mdrp_pkg;

  localparam int AW_DEFAULT = 7;

  localparam logic [1:0] MDOPC_NOP = 2'b00;
  localparam logic [1:0] MDOPC_WR  = 2'b01;
  localparam logic [1:0] MDOPC_RD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEEK = 3'd1,
    ST_OP   = 3'd2,
    ST_RDW  = 3'd3,
    ST_VFY  = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  function automatic logic [1:0] op_code(input logic wr);
    return wr ? MDOPC_WR : MDOPC_RD;
  endfunction

endpackage

// File: rtl/pll_mdrp_master.sv
// Single-register read/write initiator for the PLL MDRP port with a shadow address pointer.
// Define PLL_MDRP_READBACK_EN to verify every write with a readback of the same register.
module pll_mdrp_master
  import pll_mdrp_pkg::*;
#(
  parameter int AW     = AW_DEFAULT,
  parameter int RD_LAT = 1
) (
  input  logic          mdclk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [7:0]    cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_rdata,
  output logic          rsp_err,
  input  logic          ptr_clr,
  output logic [1:0]    mdopc,
  output logic          mdainc,
  output logic [7:0]    mdwdi,
  input  logic [7:0]    mdrdo
);

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  // Handshakes: a command transfers on the edge where cmd_valid and cmd_ready are both
  // high; a response transfers on the edge where rsp_valid and rsp_ready are both high,
  // and rsp_valid/rsp_rdata/rsp_err hold unchanged until then.

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [AW-1:0] steps, steps_nxt;
  logic [1:0]    lat, lat_nxt;
  logic          op_wr, op_wr_nxt;
  logic [7:0]    wdata, wdata_nxt;
  logic          cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt, mdainc_nxt;
  logic [7:0]    rsp_rdata_nxt, mdwdi_nxt;
  logic [1:0]    mdopc_nxt;
  logic [AW-1:0] diff;
  logic          busy;

  // A pointer clear in the accept cycle means the seek starts from 0.
  assign diff = cmd_addr - (ptr_clr ? '0 : ptr);
  assign busy = (state == ST_SEEK) || (state == ST_OP) ||
                (state == ST_RDW) || (state == ST_VFY);

  always_ff @(posedge mdclk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_nxt = (diff != '0) ? ST_SEEK : ST_OP;
      ST_SEEK: if (steps == AW'(1)) state_nxt = ST_OP;
`ifdef PLL_MDRP_READBACK_EN
      ST_OP:   state_nxt = op_wr ? ST_VFY : ST_RDW;
      ST_VFY:  state_nxt = ST_RDW;
`else
      ST_OP:   state_nxt = op_wr ? ST_RESP : ST_RDW;
`endif
      ST_RDW:  if (lat == '0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (ptr_clr && busy) state_nxt = ST_RESP;
  end

  always_comb begin
    ptr_nxt       = ptr;
    steps_nxt     = steps;
    lat_nxt       = lat;
    op_wr_nxt     = op_wr;
    wdata_nxt     = wdata;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    mdopc_nxt     = MDOPC_NOP;
    mdainc_nxt    = 1'b0;
    mdwdi_nxt     = 8'h00;
    case (state)
      ST_IDLE: if (cmd_valid) begin
        op_wr_nxt     = cmd_wr;
        wdata_nxt     = cmd_wdata;
        steps_nxt     = diff;
        rsp_rdata_nxt = 8'h00;
        rsp_err_nxt   = 1'b0;
        if (diff != '0) begin
          mdainc_nxt = 1'b1;
        end else begin
          mdopc_nxt = op_code(cmd_wr);
          mdwdi_nxt = cmd_wr ? cmd_wdata : 8'h00;
        end
      end
      ST_SEEK: begin
        ptr_nxt   = ptr + AW'(1);
        steps_nxt = steps - AW'(1);
        if (steps == AW'(1)) begin
          mdopc_nxt = op_code(op_wr);
          mdwdi_nxt = op_wr ? wdata : 8'h00;
        end else begin
          mdainc_nxt = 1'b1;
        end
      end
      ST_OP: begin
        lat_nxt = LAT_INIT;
`ifdef PLL_MDRP_READBACK_EN
        if (op_wr) mdopc_nxt = MDOPC_RD;
`else
        if (op_wr) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = 8'h00;
          rsp_err_nxt   = 1'b0;
        end
`endif
      end
      ST_VFY: lat_nxt = LAT_INIT;
      ST_RDW: begin
        if (lat == '0) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = mdrdo;
`ifdef PLL_MDRP_READBACK_EN
          rsp_err_nxt   = op_wr && (mdrdo != wdata);
`else
          rsp_err_nxt   = 1'b0;
`endif
        end else begin
          lat_nxt = lat - 2'd1;
        end
      end
      ST_RESP: if (rsp_ready) rsp_valid_nxt = 1'b0;
      default: ;
    endcase
    // A PLL reset wins over any increment and aborts whatever is in flight.
    if (ptr_clr) begin
      ptr_nxt = '0;
      if (busy) begin
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = 8'h00;
        rsp_err_nxt   = 1'b1;
        mdopc_nxt     = MDOPC_NOP;
        mdainc_nxt    = 1'b0;
        mdwdi_nxt     = 8'h00;
      end
    end
    cmd_ready_nxt = (state_nxt == ST_IDLE);
  end

  always_ff @(posedge mdclk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      steps     <= '0;
      lat       <= '0;
      op_wr     <= 1'b0;
      wdata     <= 8'h00;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
      mdopc     <= MDOPC_NOP;
      mdainc    <= 1'b0;
      mdwdi     <= 8'h00;
    end else begin
      ptr       <= ptr_nxt;
      steps     <= steps_nxt;
      lat       <= lat_nxt;
      op_wr     <= op_wr_nxt;
      wdata     <= wdata_nxt;
      cmd_ready <= cmd_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      mdopc     <= mdopc_nxt;
      mdainc    <= mdainc_nxt;
      mdwdi     <= mdwdi_nxt;
    end
  end

endmodule
